// File: rtl/fadd16_op_sequencer_if.sv
// rtl/fadd16_op_sequencer_if.sv - rounding-mode type and the sequencer's stream/adder bundle
// Optional out_nan member is present only when FADD16_SEQ_NAN_FLAG_EN is defined.
package fadd16_seq_pkg;
    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fpu_rounding_mode_t;
endpackage

interface fadd16_op_sequencer_if;
    import fadd16_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_a;
    logic [15:0]        in_b;
    fpu_rounding_mode_t in_rm;
    logic [15:0]        float1;
    logic [15:0]        float2;
    fpu_rounding_mode_t rounding_mode;
    logic [15:0]        sum;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_sum;
    logic               busy;

`ifdef FADD16_SEQ_NAN_FLAG_EN
    logic               out_nan;

    modport master (
        input  in_valid, in_a, in_b, in_rm, sum, out_ready,
        output in_ready, float1, float2, rounding_mode, out_valid, out_sum, busy, out_nan
    );
    modport slave (
        output in_valid, in_a, in_b, in_rm, sum, out_ready,
        input  in_ready, float1, float2, rounding_mode, out_valid, out_sum, busy, out_nan
    );
`else
    modport master (
        input  in_valid, in_a, in_b, in_rm, sum, out_ready,
        output in_ready, float1, float2, rounding_mode, out_valid, out_sum, busy
    );
    modport slave (
        output in_valid, in_a, in_b, in_rm, sum, out_ready,
        input  in_ready, float1, float2, rounding_mode, out_valid, out_sum, busy
    );
`endif
endinterface

// File: rtl/fadd16_op_sequencer.sv
// rtl/fadd16_op_sequencer.sv - issues one FP16 add at a time to fadd16 and queues sums in a FWFT FIFO
// Define FADD16_SEQ_NAN_FLAG_EN to store a per-entry NaN flag and expose out_nan.
module fadd16_op_sequencer
    import fadd16_seq_pkg::*;
#(
    parameter int ADD_LATENCY = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fadd16_op_sequencer_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
`ifdef FADD16_SEQ_NAN_FLAG_EN
    localparam int FW = 17;
`else
    localparam int FW = 16;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [15:0]        r_float1;
    logic [15:0]        r_float2;
    fpu_rounding_mode_t r_rm;

    logic [FW-1:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      w_count;
    logic [FW-1:0]      w_wdata;
    logic [FW-1:0]      w_head;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_pop   = (w_count != '0) && bus.out_ready;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

`ifdef FADD16_SEQ_NAN_FLAG_EN
    logic w_nan;
    assign w_nan       = (bus.sum[14:10] == 5'h1F) && (bus.sum[9:0] != 10'd0);
    assign w_wdata     = {w_nan, bus.sum};
    assign bus.out_nan = w_head[16];
`else
    assign w_wdata     = bus.sum;
`endif

    // A slot is free at accept and only pops happen before the capture, so the write never overflows.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = !rst && (w_count < PW'(FIFO_DEPTH));
                w_accept   = bus.in_valid && w_in_ready;
                if (w_accept) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_push      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_float1 <= 16'h0000;
            r_float2 <= 16'h0000;
            r_rm     <= RM_RNE;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_float1 <= bus.in_a;
                r_float2 <= bus.in_b;
                r_rm     <= bus.in_rm;
                r_cnt    <= 4'(ADD_LATENCY);
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.float1        = r_float1;
    assign bus.float2        = r_float2;
    assign bus.rounding_mode = r_rm;
    assign bus.out_valid     = (w_count != '0);
    assign bus.out_sum       = w_head[15:0];
    assign bus.busy          = (r_state != S_IDLE);
endmodule
